// File: rtl/conv_seq_pkg.sv
// Shared types and helpers for the convolution tile sequencer.
// Holds the FSM state encoding and a $clog2 variant that never returns 0.
// No ports; imported by conv_tile_sequencer and conv_seq_addr_gen.
package conv_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_MAC,
      ST_DRAIN,
      ST_DONE
   } conv_seq_state_t;

   // Counter width for a modulus n; a 1-entry counter still needs one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_seq_addr_gen.sv
// Address register: loads a base, advances by ADDR_STEP on step_i, else holds.
// Latency: new value visible the cycle after load_i/step_i; no backpressure of its own.
// Ports: clk, rst_n (async low), load_i/base_i (base load), step_i (advance), addr_o.
module conv_seq_addr_gen #(
   parameter int ADDR_W    = 32,
   parameter int ADDR_STEP = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic              step_i,
   output logic [ADDR_W-1:0] addr_o
);

   logic [ADDR_W-1:0] addr_q;

   // Load wins over step; the sum wraps modulo 2^ADDR_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else if (load_i) begin
         addr_q <= base_i;
      end else if (step_i) begin
         addr_q <= addr_q + ADDR_W'(ADDR_STEP);
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/conv_tile_sequencer.sv
// Tile controller: per pass runs NIF fetch/load/KX*KX-MAC rounds, then drains POF words; TOF/POF passes.
// Latency: FETCH one cycle after start-accept; Moore outputs from registered state and counters.
// Backpressure: FETCH waits on rd_ack, DRAIN holds wr_valid/wr_sel/wr_addr until wr_ready.
// Ports: start/rd_base/wr_base (tile launch), rd_req/rd_addr/rd_ack (fetch), dp_clear/dp_load/dp_mac_en
// (datapath), wr_valid/wr_ready/wr_sel/wr_addr (drain), pass_done/tile_done/busy (status), stall_cycles.
// Build option: define CONV_SEQ_PERF_EN to count FETCH/DRAIN stall cycles in stall_cycles.
module conv_tile_sequencer
   import conv_seq_pkg::*;
#(
   parameter int KX        = 3,
   parameter int NIF       = 4,
   parameter int POF       = 2,
   parameter int TOF       = 4,
   parameter int ADDR_W    = 32,
   parameter int ADDR_STEP = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [ADDR_W-1:0]            rd_base,
   input  logic [ADDR_W-1:0]            wr_base,
   output logic                         rd_req,
   output logic [ADDR_W-1:0]            rd_addr,
   input  logic                         rd_ack,
   output logic                         dp_clear,
   output logic                         dp_load,
   output logic                         dp_mac_en,
   output logic                         wr_valid,
   input  logic                         wr_ready,
   output logic [clog2_min1(POF)-1:0]   wr_sel,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic                         pass_done,
   output logic                         tile_done,
   output logic                         busy,
   output logic [31:0]                  stall_cycles
);

   localparam int POF_SAFE = (POF < 1) ? 1 : POF;
   localparam int NPASS    = TOF / POF_SAFE;
   localparam int K2       = KX * KX;
   localparam int MAP_W    = clog2_min1(NIF);
   localparam int PASS_W   = clog2_min1(NPASS);
   localparam int BEAT_W   = clog2_min1(POF);
   localparam int KC_W     = clog2_min1(K2);

   localparam logic [MAP_W-1:0]  MAP_LAST  = MAP_W'(NIF - 1);
   localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NPASS - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(POF - 1);
   localparam logic [KC_W-1:0]   KC_LAST   = KC_W'(K2 - 1);

   generate
      if ((POF < 1) || (NIF < 1) || ((TOF % POF_SAFE) != 0)) begin : g_bad_cfg
         $error("conv_tile_sequencer: need NIF>=1, POF>=1 and TOF divisible by POF");
      end
   endgenerate

   conv_seq_state_t    state_q;
   logic [MAP_W-1:0]   map_q;
   logic [PASS_W-1:0]  pass_q;
   logic [BEAT_W-1:0]  beat_q;
   logic [KC_W-1:0]    kcnt_q;
   logic               clr_q;
   logic               pass_done_q;

   logic start_acc;
   logic rd_step;
   logic wr_step;

   assign start_acc = (state_q == ST_IDLE) && start;
   assign rd_step   = (state_q == ST_FETCH) && rd_ack;
   assign wr_step   = (state_q == ST_DRAIN) && wr_ready;

   // clr_q is raised only on entry to the first FETCH of a pass, so a FETCH
   // stretched by a late rd_ack still clears the accumulators exactly once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         map_q       <= '0;
         pass_q      <= '0;
         beat_q      <= '0;
         kcnt_q      <= '0;
         clr_q       <= 1'b0;
         pass_done_q <= 1'b0;
      end else begin
         clr_q       <= 1'b0;
         pass_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  map_q   <= '0;
                  pass_q  <= '0;
                  beat_q  <= '0;
                  clr_q   <= 1'b1;
                  state_q <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (rd_ack) begin
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               kcnt_q  <= '0;
               state_q <= ST_MAC;
            end
            ST_MAC: begin
               if (kcnt_q == KC_LAST) begin
                  if (map_q == MAP_LAST) begin
                     beat_q  <= '0;
                     state_q <= ST_DRAIN;
                  end else begin
                     map_q   <= map_q + 1'b1;
                     state_q <= ST_FETCH;
                  end
               end else begin
                  kcnt_q <= kcnt_q + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (wr_ready) begin
                  if (beat_q == BEAT_LAST) begin
                     pass_done_q <= 1'b1;
                     beat_q      <= '0;
                     if (pass_q == PASS_LAST) begin
                        state_q <= ST_DONE;
                     end else begin
                        pass_q  <= pass_q + 1'b1;
                        map_q   <= '0;
                        clr_q   <= 1'b1;
                        state_q <= ST_FETCH;
                     end
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Read addresses run linearly through every pass (weights differ per pass).
   conv_seq_addr_gen #(
      .ADDR_W   (ADDR_W),
      .ADDR_STEP(ADDR_STEP)
   ) u_rd_addr (
      .clk   (clk),
      .rst_n (rst_n),
      .load_i(start_acc),
      .base_i(rd_base),
      .step_i(rd_step),
      .addr_o(rd_addr)
   );

   conv_seq_addr_gen #(
      .ADDR_W   (ADDR_W),
      .ADDR_STEP(ADDR_STEP)
   ) u_wr_addr (
      .clk   (clk),
      .rst_n (rst_n),
      .load_i(start_acc),
      .base_i(wr_base),
      .step_i(wr_step),
      .addr_o(wr_addr)
   );

   assign rd_req    = (state_q == ST_FETCH);
   assign dp_clear  = clr_q;
   assign dp_load   = (state_q == ST_LOAD);
   assign dp_mac_en = (state_q == ST_MAC);
   assign wr_valid  = (state_q == ST_DRAIN);
   assign wr_sel    = (state_q == ST_DRAIN) ? beat_q : '0;
   assign pass_done = pass_done_q;
   assign tile_done = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);

`ifdef CONV_SEQ_PERF_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (start_acc) begin
         stall_q <= '0;
      end else if (((state_q == ST_FETCH) && !rd_ack) || ((state_q == ST_DRAIN) && !wr_ready)) begin
         if (stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_conv_tile_sequencer.sv
module tb_conv_tile_sequencer;

   localparam int KX = 3, NIF = 4, POF = 2, TOF = 4, AW = 32, STEP = 4;
   localparam int K2 = KX * KX;
   localparam int NPASS = TOF / POF;
   localparam logic [31:0] RD_BASE = 32'h100;
   localparam logic [31:0] WR_BASE = 32'h800;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // main DUT (default parameters)
   logic          start = 1'b0, rd_ack = 1'b0, wr_ready = 1'b0;
   logic [AW-1:0] rd_base = RD_BASE, wr_base = WR_BASE;
   logic          rd_req, dp_clear, dp_load, dp_mac_en, wr_valid, pass_done, tile_done, busy;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [0:0]    wr_sel;
   logic [31:0]   stall_cycles;

   conv_tile_sequencer #(.KX(KX), .NIF(NIF), .POF(POF), .TOF(TOF), .ADDR_W(AW), .ADDR_STEP(STEP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rd_base(rd_base), .wr_base(wr_base),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .dp_clear(dp_clear), .dp_load(dp_load),
      .dp_mac_en(dp_mac_en), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
      .wr_addr(wr_addr), .pass_done(pass_done), .tile_done(tile_done), .busy(busy),
      .stall_cycles(stall_cycles)
   );

   // small DUT: NIF=POF=TOF=1
   logic          s_start = 1'b0, s_rd_ack = 1'b1, s_wr_ready = 1'b1;
   logic [AW-1:0] s_rd_base = 32'h40, s_wr_base = 32'h900;
   logic          s_rd_req, s_dp_clear, s_dp_load, s_dp_mac_en, s_wr_valid, s_pass_done, s_tile_done, s_busy;
   logic [AW-1:0] s_rd_addr, s_wr_addr;
   logic [0:0]    s_wr_sel;
   logic [31:0]   s_stall_cycles;

   conv_tile_sequencer #(.KX(3), .NIF(1), .POF(1), .TOF(1), .ADDR_W(AW), .ADDR_STEP(STEP)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(s_start), .rd_base(s_rd_base), .wr_base(s_wr_base),
      .rd_req(s_rd_req), .rd_addr(s_rd_addr), .rd_ack(s_rd_ack), .dp_clear(s_dp_clear),
      .dp_load(s_dp_load), .dp_mac_en(s_dp_mac_en), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
      .wr_sel(s_wr_sel), .wr_addr(s_wr_addr), .pass_done(s_pass_done), .tile_done(s_tile_done),
      .busy(s_busy), .stall_cycles(s_stall_cycles)
   );

   int err_cnt = 0;
   int chk_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // scoreboard queues
   logic [31:0] exp_rd_q[$];
   logic [31:0] exp_wr_q[$];
   int          exp_sel_q[$];
   int          exp_pd_q[$];
   int          exp_td_q[$];
   int          exp_mac;
   int          exp_stall;

   // monitor state
   int   c0 = 0;
   int   fetch_n = 0;
   int   mac_n = 0;
   int   td_n = 0;
   logic prev_req = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (start && !busy) begin
            c0 = cyc;
            fetch_n = 0;
            mac_n = 0;
         end
         if (rd_req && !prev_req)
            chk("dp_clear_first_fetch", dp_clear, (fetch_n % NIF) == 0);
         if (rd_req && rd_ack) begin
            if (exp_rd_q.size() == 0) chk("rd_unexpected", rd_req, 0);
            else chk("rd_addr", rd_addr, exp_rd_q.pop_front());
            fetch_n++;
         end
         if (dp_mac_en) mac_n++;
         if (wr_valid && wr_ready) begin
            if (exp_wr_q.size() == 0) chk("wr_unexpected", wr_valid, 0);
            else begin
               chk("wr_addr", wr_addr, exp_wr_q.pop_front());
               chk("wr_sel", wr_sel, exp_sel_q.pop_front());
            end
         end
         if (pass_done) begin
            if (exp_pd_q.size() == 0) chk("pass_done_unexpected", pass_done, 0);
            else chk("pass_done_cycle", cyc - c0, exp_pd_q.pop_front());
         end
         if (tile_done) begin
            td_n++;
            if (exp_td_q.size() == 0) chk("tile_done_unexpected", tile_done, 0);
            else chk("tile_done_cycle", cyc - c0, exp_td_q.pop_front());
         end
         prev_req = rd_req;
      end else begin
         prev_req = 1'b0;
      end
   end

   // driver state
   int ack_delay = 0;
   int fetch_wait = 0;
   int hold_left = 0;
   bit mid_arm = 1'b0;

   // Advance one cycle, then set inputs for the new cycle from the DUT's current outputs.
   task automatic step();
      @(posedge clk);
      #1;
      start = 1'b0;
      if (mid_arm && dp_mac_en) begin
         start = 1'b1;
         mid_arm = 1'b0;
      end
      if (ack_delay == 0) rd_ack = 1'b1;
      else if (rd_req) begin
         rd_ack = (fetch_wait >= ack_delay);
         fetch_wait = rd_ack ? 0 : fetch_wait + 1;
      end else rd_ack = 1'b0;
      if (wr_valid && hold_left > 0) begin
         wr_ready = 1'b0;
         chk("hold_wr_sel", wr_sel, 0);
         chk("hold_wr_addr", wr_addr, WR_BASE);
         hold_left--;
      end else wr_ready = 1'b1;
   endtask

   task automatic push_expect(input int delay, input int hold);
      int t;
      for (int i = 0; i < NPASS * NIF; i++) exp_rd_q.push_back(RD_BASE + 32'(i * STEP));
      for (int j = 0; j < TOF; j++) begin
         exp_wr_q.push_back(WR_BASE + 32'(j * STEP));
         exp_sel_q.push_back(j % POF);
      end
      t = 1;
      for (int p = 0; p < NPASS; p++) begin
         t += NIF * (2 + K2 + delay) + POF + ((p == 0) ? hold : 0);
         exp_pd_q.push_back(t);
      end
      exp_td_q.push_back(t);
      exp_mac = NPASS * NIF * K2;
`ifdef CONV_SEQ_PERF_EN
      exp_stall = NPASS * NIF * delay + hold;
`else
      exp_stall = 0;
`endif
   endtask

   task automatic run_tile(input int delay, input int hold, input bit mid);
      int n;
      ack_delay = delay;
      fetch_wait = 0;
      hold_left = hold;
      mid_arm = mid;
      td_n = 0;
      push_expect(delay, hold);
      start = 1'b1;
      n = 0;
      while (exp_td_q.size() != 0 && n < 3000) begin
         step();
         n++;
      end
      chk("tile_timeout_pending", exp_td_q.size(), 0);
      repeat (10) step();
      chk("rd_left", exp_rd_q.size(), 0);
      chk("wr_left", exp_wr_q.size(), 0);
      chk("pass_done_left", exp_pd_q.size(), 0);
      chk("mac_cycles", mac_n, exp_mac);
      chk("tile_done_count", td_n, 1);
      chk("stall_cycles", stall_cycles, exp_stall);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      int n;
      int s_mac, s_rd, s_wr, s_td;
      logic [31:0] s_last_wr;

      // reset state
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_rd_req", rd_req, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_stall", stall_cycles, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // nominal tile, acks tied high
      run_tile(0, 0, 1'b0);
      // rd_ack delayed 3 cycles on every fetch
      run_tile(3, 0, 1'b0);
      // wr_ready low 5 cycles on the first drain beat
      run_tile(0, 5, 1'b0);
      // start pulsed during MAC must be ignored
      run_tile(0, 0, 1'b1);

      // reset in the middle of DRAIN
      ack_delay = 0;
      hold_left = 0;
      push_expect(0, 0);
      start = 1'b1;
      n = 0;
      while (!wr_valid && n < 500) begin
         step();
         n++;
      end
      chk("reach_drain", wr_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_wr_valid", wr_valid, 0);
      chk("arst_wr_addr", wr_addr, 0);
      chk("arst_rd_addr", rd_addr, 0);
      chk("arst_ctl", {rd_req, dp_clear, dp_load, dp_mac_en, wr_sel, pass_done, tile_done}, 0);
      chk("arst_stall", stall_cycles, 0);
      exp_rd_q.delete();
      exp_wr_q.delete();
      exp_sel_q.delete();
      exp_pd_q.delete();
      exp_td_q.delete();
      step();
      step();
      rst_n = 1'b1;
      step();
      run_tile(0, 0, 1'b0);

      // minimal configuration on the second instance
      s_mac = 0; s_rd = 0; s_wr = 0; s_td = -1; s_last_wr = 32'h0;
      s_start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         s_start = 1'b0;
         if (s_dp_mac_en) s_mac++;
         if (s_rd_req && s_rd_ack) s_rd++;
         if (s_wr_valid && s_wr_ready) begin
            s_wr++;
            s_last_wr = s_wr_addr;
         end
         if (s_tile_done && s_td < 0) s_td = k;
      end
      chk("small_mac", s_mac, 9);
      chk("small_fetch", s_rd, 1);
      chk("small_writes", s_wr, 1);
      chk("small_wr_addr", s_last_wr, 32'h900);
      chk("small_tile_done_cycle", s_td, 13);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
